// File: rtl/scrambler_par.sv
`default_nettype none
// ============================================================================
// Module   : scrambler_par
// Brief    : W-bit/cycle 802.11a scrambler/descrambler (x^7 + x^4 + 1) with
//            seed register and per-frame reseed / SERVICE-bit seed recovery.
// Revision : 1.0
// ============================================================================

module scrambler_par #(
  parameter int         W    = 8,
  parameter logic [6:0] SEED = 7'b1011101
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         clear,
  input  logic         seed_load,
  input  logic [6:0]   seed_in,
  input  logic         mode,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  input  logic         in_last,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic         out_last,
  output logic         locked
);

  localparam logic [2:0] C_SYNC_BITS = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SYNC = 2'd1,
    ST_RUN  = 2'd2
  } state_t;

  state_t       r_state;
  state_t       w_state_nxt;
  logic [6:0]   r_seed;
  logic [6:0]   r_lfsr;
  logic [6:0]   w_lfsr_start;
  logic [6:0]   w_lfsr_nxt;
  logic [2:0]   r_sync_cnt;
  logic [2:0]   w_sync_cnt_nxt;
  logic         r_mode;
  logic         w_mode_eff;
  logic         w_accept;
  logic         w_seed_wr;
  logic         w_locked_nxt;
  logic [W-1:0] w_out_data;

  assign in_ready  = !out_valid || out_ready;
  assign w_accept  = in_valid && in_ready && !clear;
  // An all-zero seed would freeze the LFSR, so it never reaches the register.
  assign w_seed_wr = seed_load && (seed_in != 7'd0);

  // Whole beat is unrolled bit by bit; sync bits may end anywhere in the beat.
  always_comb begin : p_datapath
    logic [6:0] w_s;
    logic [2:0] w_cnt;
    logic       w_fb;
    w_mode_eff = (r_state == ST_IDLE) ? mode : r_mode;
    if (r_state == ST_IDLE) begin
      w_lfsr_start = w_seed_wr ? seed_in : r_seed;
      w_cnt        = 3'd0;
    end else begin
      w_lfsr_start = r_lfsr;
      w_cnt        = r_sync_cnt;
    end
    w_s        = w_lfsr_start;
    w_fb       = 1'b0;
    w_out_data = '0;
    for (int i = 0; i < W; i++) begin
      w_fb = w_s[6] ^ w_s[3];
      if (w_mode_eff && (w_cnt < C_SYNC_BITS)) begin
        w_out_data[i] = 1'b0;
        w_s           = {w_s[5:0], in_data[i]};
        w_cnt         = w_cnt + 3'd1;
      end else begin
        w_out_data[i] = in_data[i] ^ w_fb;
        w_s           = {w_s[5:0], w_fb};
      end
    end
    w_lfsr_nxt     = w_s;
    w_sync_cnt_nxt = w_cnt;
  end

  always_comb begin : p_fsm_next
    w_state_nxt  = r_state;
    w_locked_nxt = locked;
    if (w_accept) begin
      if (in_last) begin
        w_state_nxt  = ST_IDLE;
        w_locked_nxt = 1'b0;
      end else if (w_mode_eff && (w_sync_cnt_nxt < C_SYNC_BITS)) begin
        w_state_nxt  = ST_SYNC;
        w_locked_nxt = 1'b0;
      end else begin
        w_state_nxt  = ST_RUN;
        w_locked_nxt = w_mode_eff;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin : p_state
    if (!reset_n) begin
      r_state    <= ST_IDLE;
      r_sync_cnt <= 3'd0;
      r_mode     <= 1'b0;
      r_lfsr     <= SEED;
      locked     <= 1'b0;
    end else if (clear) begin
      r_state    <= ST_IDLE;
      r_sync_cnt <= 3'd0;
      locked     <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      locked  <= w_locked_nxt;
      if (w_accept) begin
        r_lfsr     <= w_lfsr_nxt;
        r_sync_cnt <= in_last ? 3'd0 : w_sync_cnt_nxt;
        if (r_state == ST_IDLE) begin
          r_mode <= mode;
        end
      end
    end
  end

  // Seed register survives clear; only reset restores the default.
  always_ff @(posedge clk or negedge reset_n) begin : p_seed
    if (!reset_n) begin
      r_seed <= SEED;
    end else if (w_seed_wr) begin
      r_seed <= seed_in;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin : p_out
    if (!reset_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
    end else if (clear) begin
      out_valid <= 1'b0;
    end else if (w_accept) begin
      out_valid <= 1'b1;
      out_data  <= w_out_data;
      out_last  <= in_last;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

`default_nettype wire

// File: doc/scrambler_par.md
# scrambler_par

Parametrised W-bit-per-cycle 802.11a scrambler/descrambler (x^7 + x^4 + 1) with a valid/ready stream interface, a programmable seed register and per-frame reseeding. In descramble mode it recovers the transmitter seed from the first 7 bits of each frame, which are the zero SERVICE bits. It sits between the PLCP bit source or sink and the convolutional encoder or decoder in both TX and RX paths.

## Interface
- W, default 8: bits per beat, legal range 1..32.
- SEED, default 7'b1011101: seed register value after reset.
- clk  in  1  rising-edge clock.
- reset_n  in  1  asynchronous, active-low reset.
- clear  in  1  synchronous abort: drops the output, returns to IDLE, seed register kept.
- seed_load  in  1  writes seed_in into the seed register.
- seed_in  in  7  new seed, bit 6 = LFSR stage x7.
- mode  in  1  0 = scramble with seed register, 1 = descramble with self-sync; sampled on the first beat of a frame.
- in_valid / in_ready  in / out  1  input handshake.
- in_data  in  W  bit 0 is first in time.
- in_last  in  1  last beat of frame.
- out_valid / out_ready  out / in  1  output handshake.
- out_data  out  W  bit 0 is first in time.
- out_last  out  1  aligned with out_data.
- locked  out  1  descramble mode: seed recovered for the current frame.

## Operation
- Beat accepted when in_valid && in_ready; in_ready = !out_valid || out_ready.
- LFSR state s[6:0]. Per bit i, in order 0..W-1:
  - fb = s[6] ^ s[3]
  - normal bit: out = d ^ fb, then s = {s[5:0], fb}
  - sync bit (mode 1, sync_cnt < 7): out = 0, then s = {s[5:0], d}, and sync_cnt increments.
- All W bits are evaluated combinationally within one beat; sync bits may straddle beats when W < 7.
- FSM states:
  - IDLE → RUN on an accepted beat with mode = 0. The LFSR is loaded from the seed register before bit 0 is processed.
  - IDLE → SYNC on an accepted beat with mode = 1. sync_cnt = 0 and the LFSR contents are don't-care.
  - SYNC → RUN when sync_cnt reaches 7, either mid-beat or at the end of a beat. locked rises at the same time.
  - Any state → IDLE on an accepted beat with in_last = 1, after that beat is processed. locked is cleared.
- A frame of 7 or fewer bits in mode 1 ends in IDLE with locked still low.
- mode_q is latched on the first beat; mode changes mid-frame are ignored.
- seed_load:
  - Writes the seed register in any state.
  - If it coincides with an accepted first beat in mode 0, seed_in (not the old register value) seeds that beat.
  - seed_in = 0 is ignored (prevents LFSR lock-up); the register keeps its previous value.
- clear: out_valid = 0, state = IDLE, sync_cnt = 0, locked = 0. Any beat presented in the same cycle is dropped. The seed register is unchanged.
- Precedence: reset_n > clear > normal operation.

## Timing
- Reset values: out_valid = 0, out_data = 0, out_last = 0, locked = 0, in_ready = 1, state = IDLE, seed register = SEED, LFSR = SEED.
- Latency: one cycle, from the accepted beat to out_valid / out_data / out_last.
- Throughput: one beat per cycle while out_ready = 1. Under backpressure the output register holds out_data and out_last stable, and in_ready = 0.
- locked is registered and updates in the same cycle as the out_valid of the beat that completes sync.
- Back-to-back frames: the first beat of frame N+1 may be accepted in the cycle after frame N's last beat and is reseeded or resynced correctly, with no idle cycle.
- Asynchronous reset mid-frame: outputs take their reset values immediately. The first beat after release starts a new frame.

## Test plan
- W = 8, reset, mode = 0, in_data = 0x00 for 1 beat with in_last → out_data = 0x36 one cycle later, out_last = 1.
- W = 8, seed_load with seed_in = 7'h7F together with the first beat, mode = 0, 16 zero beats → first out_data = 0x70. The 127-bit output sequence repeats at bit 127.
- W = 8, loopback: scramble a random frame whose first 7 bits are 0, using seed 7'h5A, then descramble (mode = 1) → output equals the input frame, and locked asserts with the first beat.
- W = 3, mode = 1: the sync span covers beats 0–2 → locked rises only on beat 2, bit 0 of beat 2 is 0, and bits 1–2 of beat 2 are correctly descrambled.
- out_ready held low for 5 cycles mid-frame → out_data and out_last stable, in_ready = 0, no beat lost or duplicated. Also: clear mid-frame → out_valid drops next cycle, and the next frame reseeds from the seed register.
- seed_in = 0 with seed_load, then a mode 0 frame → output matches the previous seed. Also: reset_n pulsed mid-frame → all outputs return to reset values asynchronously.
